hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the five-stage RISC-V core, sitting beside the ID/EX/MEM/WB pipeline registers. It generates EX-stage operand forwarding selects, load-use and no-forwarding RAW stalls, branch flushes, and multi-cycle-operation (MUL/DIV) stalls through a small state machine. It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: EX operand forwarding, load-use / RAW stalls, branch flushes,
// MUL/DIV occupancy FSM and saturating stall/flush counters for the 5-stage core.
// Ports: clk, rst (async, active-low); E/M/W write-enables and rd; D/E rs1/rs2;
// PCSrcE, MulStartE, clr_cnt in; ForwardAE/BE, Stall{F,D,E}, Flush{D,E,M}, busy,
// stall_cnt, flush_cnt out.
module hazard_ctrl_unit #(
    parameter int REG_AW     = 5,
    parameter int ENABLE_FWD = 1,
    parameter int MC_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic              PCSrcE,
    input  logic              MulStartE,
    input  logic              clr_cnt,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int BW = $clog2(MC_LAT);
    localparam logic FWD_ON = (ENABLE_FWD != 0);

    typedef enum logic {RUN, BUSY} state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     busy_cnt_q, busy_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [1:0] fa, fb;
    logic       lw_stall, raw_stall, mc_stall;
    logic       data_stall, br_flush;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] s;
        s = 2'b00;
        if (RegWriteM && RdM != '0 && RdM == rs)
            s = 2'b10;
        else if (RegWriteW && RdW != '0 && RdW == rs)
            s = 2'b01;
        return s;
    endfunction

    function automatic logic raw_hit(input logic [REG_AW-1:0] rs);
        return rs != '0 &&
               ((RegWriteE && rs == RdE) || (RegWriteM && rs == RdM));
    endfunction

    always_comb begin
        fa = FWD_ON ? fwd_sel(Rs1E) : 2'b00;
        fb = FWD_ON ? fwd_sel(Rs2E) : 2'b00;
        lw_stall = ResultSrcE0 && RdE != '0 &&
                   (RdE == Rs1D || RdE == Rs2D);
        // W needs no check: the register file writes in the first half-cycle
        raw_stall = !FWD_ON && (raw_hit(Rs1D) || raw_hit(Rs2D));
        mc_stall = (state_q == RUN && MulStartE) || state_q == BUSY;
        // a taken branch discards D, so its data stall is moot
        data_stall = (lw_stall || raw_stall) && !PCSrcE && !mc_stall;
        br_flush = PCSrcE && !mc_stall;
    end

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        unique case (state_q)
            RUN: begin
                if (MulStartE) begin
                    state_d    = BUSY;
                    busy_cnt_d = BW'(MC_LAT - 1);
                end
            end
            BUSY: begin
                if (busy_cnt_q == BW'(1)) begin
                    state_d    = RUN;
                    busy_cnt_d = '0;
                end else begin
                    busy_cnt_d = busy_cnt_q - BW'(1);
                end
            end
            default: begin
                state_d    = RUN;
                busy_cnt_d = '0;
            end
        endcase
    end

    // outputs are forced quiet while reset is held, independent of inputs
    always_comb begin
        ForwardAE = rst ? fa : 2'b00;
        ForwardBE = rst ? fb : 2'b00;
        StallF    = rst && (data_stall || mc_stall);
        StallD    = rst && (data_stall || mc_stall);
        StallE    = rst && mc_stall;
        FlushD    = rst && br_flush;
        FlushE    = rst && (br_flush || data_stall);
        FlushM    = rst && mc_stall;
        busy      = (state_q == BUSY);
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (StallF && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (FlushD && flush_cnt_q != '1)
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: forwarding and no-forwarding instances driven in lockstep,
// checked every cycle against a cycle-count reference model plus directed checks.
module tb_hazard_ctrl_unit;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE0;
    logic [AW-1:0] RdE, RdM, RdW, Rs1D, Rs2D, Rs1E, Rs2E;
    logic PCSrcE, MulStartE, clr_cnt;

    logic [1:0]    fa [2];
    logic [1:0]    fb [2];
    logic          sf [2];
    logic          sd [2];
    logic          se [2];
    logic          fd [2];
    logic          fe [2];
    logic          fm [2];
    logic          bz [2];
    logic [CW-1:0] scn [2];
    logic [CW-1:0] fcn [2];

    int tests = 0;
    int fails = 0;

    int busy_left;
    int scnt [2];
    int fcnt [2];

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic sf, sd, se, fd, fe, fm;
    } hz_t;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(AW), .ENABLE_FWD(1), .MC_LAT(LAT), .CNT_W(CW)) u_fwd (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .PCSrcE(PCSrcE), .MulStartE(MulStartE), .clr_cnt(clr_cnt),
        .ForwardAE(fa[0]), .ForwardBE(fb[0]),
        .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]),
        .FlushD(fd[0]), .FlushE(fe[0]), .FlushM(fm[0]),
        .busy(bz[0]), .stall_cnt(scn[0]), .flush_cnt(fcn[0])
    );

    hazard_ctrl_unit #(.REG_AW(AW), .ENABLE_FWD(0), .MC_LAT(LAT), .CNT_W(CW)) u_nofwd (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .PCSrcE(PCSrcE), .MulStartE(MulStartE), .clr_cnt(clr_cnt),
        .ForwardAE(fa[1]), .ForwardBE(fb[1]),
        .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]),
        .FlushD(fd[1]), .FlushE(fe[1]), .FlushM(fm[1]),
        .busy(bz[1]), .stall_cnt(scn[1]), .flush_cnt(fcn[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fsel(input logic [AW-1:0] r);
        if (RegWriteM && RdM != 0 && RdM == r) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit dep(input logic [AW-1:0] r);
        return r != 0 && ((RegWriteE && r == RdE) || (RegWriteM && r == RdM));
    endfunction

    function automatic hz_t model_hz(input int i);
        hz_t h;
        bit fwd, mc, lw, raw, ds, br;
        h = '0;
        if (rst !== 1'b1) return h;
        fwd = (i == 0);
        mc  = (busy_left > 0) || MulStartE;
        lw  = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        raw = !fwd && (dep(Rs1D) || dep(Rs2D));
        ds  = (lw || raw) && !PCSrcE && !mc;
        br  = PCSrcE && !mc;
        h.fa = fwd ? fsel(Rs1E) : 2'b00;
        h.fb = fwd ? fsel(Rs2E) : 2'b00;
        h.sf = ds || mc;
        h.sd = ds || mc;
        h.se = mc;
        h.fd = br;
        h.fe = br || ds;
        h.fm = mc;
        return h;
    endfunction

    task automatic check_all(input string ctx);
        hz_t h;
        if (rst !== 1'b1) begin
            busy_left = 0;
            scnt = '{0, 0};
            fcnt = '{0, 0};
        end
        for (int i = 0; i < 2; i++) begin
            h = model_hz(i);
            chk($sformatf("%s/%0d/FwdA", ctx, i), 32'(fa[i]), 32'(h.fa));
            chk($sformatf("%s/%0d/FwdB", ctx, i), 32'(fb[i]), 32'(h.fb));
            chk($sformatf("%s/%0d/StallF", ctx, i), 32'(sf[i]), 32'(h.sf));
            chk($sformatf("%s/%0d/StallD", ctx, i), 32'(sd[i]), 32'(h.sd));
            chk($sformatf("%s/%0d/StallE", ctx, i), 32'(se[i]), 32'(h.se));
            chk($sformatf("%s/%0d/FlushD", ctx, i), 32'(fd[i]), 32'(h.fd));
            chk($sformatf("%s/%0d/FlushE", ctx, i), 32'(fe[i]), 32'(h.fe));
            chk($sformatf("%s/%0d/FlushM", ctx, i), 32'(fm[i]), 32'(h.fm));
            chk($sformatf("%s/%0d/busy", ctx, i), 32'(bz[i]), 32'(busy_left > 0));
            chk($sformatf("%s/%0d/scnt", ctx, i), 32'(scn[i]), 32'(scnt[i]));
            chk($sformatf("%s/%0d/fcnt", ctx, i), 32'(fcn[i]), 32'(fcnt[i]));
        end
    endtask

    task automatic tick(input string ctx);
        hz_t h;
        #1;
        check_all(ctx);
        @(posedge clk);
        if (rst === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                h = model_hz(i);
                if (clr_cnt) begin
                    scnt[i] = 0;
                    fcnt[i] = 0;
                end else begin
                    if (h.sf && scnt[i] < CMAX) scnt[i]++;
                    if (h.fd && fcnt[i] < CMAX) fcnt[i]++;
                end
            end
            if (busy_left > 0) busy_left--;
            else if (MulStartE) busy_left = LAT - 1;
        end
        #1;
    endtask

    task automatic idle();
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0;
        RdE = 0; RdM = 0; RdW = 0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        PCSrcE = 0; MulStartE = 0; clr_cnt = 0;
    endtask

    initial begin
        int n_stall, n_busy, f0;
        busy_left = 0;
        scnt = '{0, 0};
        fcnt = '{0, 0};
        rst = 1'b0;
        idle();
        tick("reset");
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7; PCSrcE = 1; MulStartE = 1;
        tick("reset_quiet");
        chk("reset_stallF", 32'(sf[0]), 0);
        chk("reset_busy", 32'(bz[0]), 0);
        idle();
        rst = 1'b1;
        tick("run0");

        RegWriteM = 1; RegWriteW = 1; RdM = 5; RdW = 5; Rs1E = 5;
        #1 chk("fwd_M_prio", 32'(fa[0]), 32'h2);
        tick("fwdM");
        RdM = 0;
        #1 chk("fwd_W", 32'(fa[0]), 32'h1);
        tick("fwdW");
        Rs1E = 0; RdW = 0;
        #1 chk("fwd_none", 32'(fa[0]), 32'h0);
        tick("fwd0");
        idle();

        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        #1 chk("lw_stallF", 32'(sf[0]), 1);
        tick("lw");
        PCSrcE = 1;
        #1 chk("lw_br_stallF", 32'(sf[0]), 0);
        chk("lw_br_flushD", 32'(fd[0]), 1);
        tick("lw_br");
        idle();

        f0 = int'(fcn[0]);
        n_stall = 0;
        n_busy = 0;
        for (int c = 0; c < 7; c++) begin
            MulStartE = (c == 0);
            PCSrcE = (c == 2);
            #1;
            n_stall += int'(sf[0] && sd[0] && se[0] && fm[0]);
            n_busy += int'(bz[0]);
            tick("mc");
        end
        chk("mc_stall_cycles", 32'(n_stall), LAT);
        chk("mc_busy_cycles", 32'(n_busy), LAT - 1);
        chk("mc_flush_cnt", 32'(fcn[0]), 32'(f0));
        idle();

        RegWriteM = 1; RdM = 3; Rs1D = 3;
        #1 chk("nofwd_raw_stall", 32'(sf[1]), 1);
        chk("nofwd_fwdA", 32'(fa[1]), 0);
        tick("raw");
        RegWriteM = 0; RdM = 0; RegWriteW = 1; RdW = 3;
        #1 chk("nofwd_W_nostall", 32'(sf[1]), 0);
        tick("rawW");
        idle();

        MulStartE = 1;
        tick("mr0");
        MulStartE = 0;
        tick("mr1");
        rst = 1'b0;
        #1 chk("rst_mid_busy", 32'(bz[0]), 0);
        chk("rst_mid_stall", 32'(sf[0]), 0);
        tick("mr_rst");
        rst = 1'b1;
        for (int c = 0; c < 3; c++) tick("post_rst");

        clr_cnt = 1;
        tick("clr");
        clr_cnt = 0;
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        for (int c = 0; c < 20; c++) tick("sat");
        chk("sat_stall_cnt", 32'(scn[0]), CMAX);
        idle();
        clr_cnt = 1;
        tick("clr2");
        chk("clr_stall_cnt", 32'(scn[0]), 0);
        clr_cnt = 0;

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(99) != 0);
            RegWriteE = 1'($urandom);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            ResultSrcE0 = ($urandom_range(3) == 0);
            RdE = AW'($urandom_range(7));
            RdM = AW'($urandom_range(7));
            RdW = AW'($urandom_range(7));
            Rs1D = AW'($urandom_range(7));
            Rs2D = AW'($urandom_range(7));
            Rs1E = AW'($urandom_range(7));
            Rs2E = AW'($urandom_range(7));
            PCSrcE = ($urandom_range(4) == 0);
            MulStartE = ($urandom_range(11) == 0);
            clr_cnt = ($urandom_range(49) == 0);
            tick("rnd");
        end
        rst = 1'b1;
        idle();
        tick("end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
